booth_div: RTL and testbench
============================

// Module: booth_div
// PURPOSE
//  Sequential signed restoring divider; the inverse-operation companion to the
//  team's sequential Booth multiplier, sharing its en/done handshake style.
//  Computes Q = A / B and R = A % B (two's complement, truncation toward zero).
//  Computes one quotient bit per cycle. Sits in the arithmetic datapath.
// PARAMETERS
//  width  8  operand, quotient and remainder width in bits (signed, >= 2)
// PORTS
//  clk       in   1      rising-edge clock (single clock domain)
//  rst_n     in   1      reset, synchronous, active-low
//  en        in   1      run enable; low freezes all state (no progress)
//  A         in   width  signed dividend, sampled in LOAD
//  B         in   width  signed divisor, sampled in LOAD
//  done      out  1      one-cycle pulse; Q/R/div_zero valid from this cycle
//  Q         out  width  signed quotient, held until next DONE
//  R         out  width  signed remainder, held until next DONE
//  div_zero  out  1      B==0 flag for the last result, held with Q/R
// BEHAVIOUR
//  - Reset: on a clk edge with rst_n=0: state=LOAD, done=0, Q=0, R=0,
//    div_zero=0, internal regs=0. Reset mid-operation aborts the division
//    immediately, with no done pulse.
//  - en=0: all regs hold, including done. A done pulse is stretched while en=0.
//  - FSM (2-bit), one transition per edge with en=1:
//    LOAD : latch |A|, |B| (width-bit unsigned magnitudes), sign_q=A[msb]^B[msb],
//           sign_r=A[msb], bz=(B==0); clear rem (width+1 bits), count=0 -> CALC
//    CALC : rem={rem,quo[msb]}, quo<<=1; if rem>=|B| then rem-=|B|, quo[0]=1;
//           count++; after width iterations -> DONE (exactly width cycles)
//    DONE : done=1; Q=sign_q ? -quo : quo; R=sign_r ? -rem : rem;
//           div_zero=bz -> CLEAR
//    CLEAR: done=0 -> LOAD
//  - Latency with en held high: LOAD is at edge 0, done is high after edge
//    width+1, and done falls after edge width+2. Throughput is one result per
//    width+3 cycles. A and B are ignored outside LOAD.
//  - Divide by zero: Q={width{1'b1}}, R=A, div_zero=1. CALC still runs width
//    cycles, so the timing is unchanged.
//  - Overflow (A=min, B=-1): magnitude 2^(width-1) wraps, giving Q=min and R=0.
//    No flag.
//  - |A|<|B|: Q=0, R=A. A=0: Q=0, R=0.
//  - Negation is two's complement within width bits. rem never exceeds |B|-1,
//    so it always fits.
// STRUCTURE
//  - Shared package/include arith_defs: FSM state constants S_LOAD=0, S_CALC=1,
//    S_DONE=2, S_CLEAR=3. The Booth multiplier reuses them.
//  - One sub-module: div_step, a combinational shift/compare/subtract for one
//    quotient bit. Inputs are rem, quo_msb and divisor; outputs are rem_next
//    and q_bit.
//  - Everything else (FSM, counter, sign fix-up, output regs) lives in the top.
// TESTING (width=8, en held high unless stated)
//  1. A=100, B=7 -> done after edge 9 for one cycle; Q=14 (0x0E), R=2, div_zero=0.
//  2. A=-100, B=7 -> Q=-14 (0xF2), R=-2 (0xFE). A=100, B=-7 -> Q=0xF2, R=2.
//     A=-100, B=-7 -> Q=14, R=0xFE.
//  3. A=-128, B=-1 -> Q=0x80, R=0. A=-128, B=1 -> Q=0x80, R=0.
//     A=127, B=127 -> Q=1, R=0.
//  4. A=5, B=0 -> Q=0xFF, R=0x05, div_zero=1, same latency. The next op 6/3
//     gives Q=2, R=0, div_zero=0.
//  5. 100/7 with en=0 for 3 cycles mid-CALC -> done is delayed by exactly
//     3 cycles; results are as in scenario 1.
//  6. rst_n=0 for one edge during CALC -> no done pulse; Q=R=0, done=0. A fresh
//     LOAD of 9/2 yields Q=4, R=1.

Source files
------------

// File: rtl/arith_defs_pkg.sv
// Shared arithmetic-datapath definitions: sequencer state encoding common to the
// sequential divider and Booth multiplier.
package arith_defs_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CALC  = 2'd1,
        S_DONE  = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    // Minimum counter width able to hold the value n.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare
// against the divisor and conditionally subtract.
module booth_div_step #(
    parameter int unsigned width = 8
) (
    input  logic [width:0]   rem,
    input  logic             quo_msb,
    input  logic [width-1:0] divisor,
    output logic [width:0]   rem_next,
    output logic             q_bit
);

    logic [width:0] shifted;
    logic [width:0] div_ext;

    always_comb begin
        shifted  = {rem[width-1:0], quo_msb};
        div_ext  = {1'b0, divisor};
        q_bit    = (shifted >= div_ext);
        rem_next = q_bit ? (shifted - div_ext) : shifted;
    end

endmodule

// File: rtl/booth_div.sv
// Sequential signed restoring divider, one quotient bit per cycle, with the
// en/done handshake shared with the Booth multiplier.
module booth_div
    import arith_defs_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             done,
    output logic [width-1:0] Q,
    output logic [width-1:0] R,
    output logic             div_zero
);

    localparam int unsigned CntW = cnt_bits(width);

    state_e            state_q;
    logic [width-1:0]  mag_b_q;
    logic [width-1:0]  quo_q;
    logic [width:0]    rem_q;
    logic [CntW-1:0]   count_q;
    logic              sign_q_q;
    logic              sign_r_q;
    logic              bz_q;
    logic              done_q;
    logic [width-1:0]  q_out_q;
    logic [width-1:0]  r_out_q;
    logic              dz_q;

    logic [width-1:0]  a_mag;
    logic [width-1:0]  b_mag;
    logic [width:0]    rem_next;
    logic              q_bit;
    logic [width-1:0]  rem_low;

    always_comb begin
        a_mag   = A[width-1] ? (~A + 1'b1) : A;
        b_mag   = B[width-1] ? (~B + 1'b1) : B;
        // The remainder is always below |B|, so its low bits hold the full value.
        rem_low = rem_q[width-1:0];
    end

    booth_div_step #(
        .width (width)
    ) u_step (
        .rem      (rem_q),
        .quo_msb  (quo_q[width-1]),
        .divisor  (mag_b_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_LOAD;
            mag_b_q  <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            count_q  <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            bz_q     <= 1'b0;
            done_q   <= 1'b0;
            q_out_q  <= '0;
            r_out_q  <= '0;
            dz_q     <= 1'b0;
        end else if (en) begin
            unique case (state_q)
                S_LOAD: begin
                    mag_b_q  <= b_mag;
                    quo_q    <= a_mag;
                    sign_q_q <= A[width-1] ^ B[width-1];
                    sign_r_q <= A[width-1];
                    bz_q     <= (B == '0);
                    rem_q    <= '0;
                    count_q  <= '0;
                    state_q  <= S_CALC;
                end
                S_CALC: begin
                    rem_q   <= rem_next;
                    quo_q   <= {quo_q[width-2:0], q_bit};
                    count_q <= count_q + 1'b1;
                    if (count_q == CntW'(width - 1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    // Divide by zero reports all-ones regardless of operand signs.
                    if (bz_q) begin
                        q_out_q <= '1;
                    end else begin
                        q_out_q <= sign_q_q ? (~quo_q + 1'b1) : quo_q;
                    end
                    r_out_q <= sign_r_q ? (~rem_low + 1'b1) : rem_low;
                    dz_q    <= bz_q;
                    state_q <= S_CLEAR;
                end
                S_CLEAR: begin
                    done_q  <= 1'b0;
                    state_q <= S_LOAD;
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign done     = done_q;
    assign Q        = q_out_q;
    assign R        = r_out_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_booth_div.sv
// Directed self-checking bench for booth_div (width=8) using immediate assertions.
module tb_booth_div;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         div_zero;

    int vectors;
    int fails;

    booth_div #(
        .width (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .A        (A),
        .B        (B),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Runs one division from LOAD. Optionally drops en for edges stall_from..stall_from+2.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall_from, input int exp_edge,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input logic exp_dz);
        int n;
        A  = a;
        B  = b;
        en = 1'b1;
        @(posedge clk);
        #1;
        A = '0;
        B = '0;
        n = 0;
        while (!done && n < 40) begin
            en = !(stall_from >= 0 && n >= stall_from && n < stall_from + 3);
            @(posedge clk);
            #1;
            n++;
        end
        en = 1'b1;
        check({tag, " latency"}, n, exp_edge);
        check({tag, " Q"}, int'(Q), int'(exp_q));
        check({tag, " R"}, int'(R), int'(exp_r));
        check({tag, " div_zero"}, int'(div_zero), int'(exp_dz));
        @(posedge clk);
        #1;
        check({tag, " done fall"}, int'(done), 0);
    endtask

    initial begin
        vectors = 0;
        fails   = 0;
        rst_n   = 1'b0;
        en      = 1'b1;
        A       = '0;
        B       = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset done", int'(done), 0);
        check("reset Q", int'(Q), 0);
        check("reset R", int'(R), 0);
        check("reset div_zero", int'(div_zero), 0);
        rst_n = 1'b1;

        run_op("100/7",    8'd100,  8'd7,   -1, 9, 8'h0E, 8'h02, 1'b0);
        run_op("-100/7",   8'h9C,   8'd7,   -1, 9, 8'hF2, 8'hFE, 1'b0);
        run_op("100/-7",   8'd100,  8'hF9,  -1, 9, 8'hF2, 8'h02, 1'b0);
        run_op("-100/-7",  8'h9C,   8'hF9,  -1, 9, 8'h0E, 8'hFE, 1'b0);
        run_op("-128/-1",  8'h80,   8'hFF,  -1, 9, 8'h80, 8'h00, 1'b0);
        run_op("-128/1",   8'h80,   8'h01,  -1, 9, 8'h80, 8'h00, 1'b0);
        run_op("127/127",  8'd127,  8'd127, -1, 9, 8'h01, 8'h00, 1'b0);
        run_op("3/10",     8'd3,    8'd10,  -1, 9, 8'h00, 8'h03, 1'b0);
        run_op("5/0",      8'd5,    8'd0,   -1, 9, 8'hFF, 8'h05, 1'b1);
        run_op("6/3",      8'd6,    8'd3,   -1, 9, 8'h02, 8'h00, 1'b0);
        run_op("100/7 stall", 8'd100, 8'd7,  3, 12, 8'h0E, 8'h02, 1'b0);

        // A done pulse must stretch while en is low.
        A  = 8'd50;
        B  = 8'd5;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
        end
        #1;
        check("stretch done rise", int'(done), 1);
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("stretch done held", int'(done), 1);
        check("stretch Q", int'(Q), 10);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("stretch done fall", int'(done), 0);

        // Reset mid-CALC aborts with no done pulse.
        A = 8'd100;
        B = 8'd7;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
        end
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort done", int'(done), 0);
        check("abort Q", int'(Q), 0);
        check("abort R", int'(R), 0);
        begin
            int seen;
            seen = 0;
            A = 8'd9;
            B = 8'd2;
            for (int i = 0; i < 9; i++) begin
                @(posedge clk);
                #1;
                if (done) seen++;
            end
            check("abort no early done", seen, 0);
            @(posedge clk);
            #1;
            check("after reset done", int'(done), 1);
            check("after reset Q", int'(Q), 4);
            check("after reset R", int'(R), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
